mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit.sv | 157 +++++++++++++++
 tb/tb_mul_div_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide, one bit per CALC cycle, with sign fix-up in FIX.
//
//   state | meaning
//   IDLE  | waiting for Start
//   CALC  | one multiplier/quotient bit per cycle, counter runs down to 0
//   FIX   | sign correction and result select, loads Result
//   DONE  | Done pulse; a new Start may be accepted here
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         f3_q, f3_d;
  logic               a_neg_q, a_neg_d, b_neg_q, b_neg_d, fast_q, fast_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d, result_q, result_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;

  logic               start_acc, is_div, a_signed, b_signed, a_neg, b_neg, is_fast;
  logic [WIDTH-1:0]   a_mag, b_mag, fast_val;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_raw, quo_fix, rem_fix, fix_val;

  assign start_acc = Start && (state_q == S_IDLE || state_q == S_DONE);
  assign is_div    = Funct3[2];
  assign a_signed  = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                     (Funct3 == 3'b100) || (Funct3 == 3'b110);
  assign b_signed  = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
  assign a_neg     = a_signed && SrcA[WIDTH-1];
  assign b_neg     = b_signed && SrcB[WIDTH-1];
  assign a_mag     = a_neg ? -SrcA : SrcA;
  assign b_mag     = b_neg ? -SrcB : SrcB;

  // Divide-by-zero and signed overflow have fixed answers and bypass CALC.
  assign is_fast   = is_div && ((SrcB == '0) ||
                     (!Funct3[0] && SrcA == MIN_NEG && SrcB == '1));
  always_comb begin
    if (SrcB == '0) fast_val = Funct3[1] ? SrcA : '1;
    else            fast_val = Funct3[1] ? '0 : MIN_NEG;
  end

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_diff = {rem_q, acc_q[WIDTH-1]} - {2'b00, opnd_q};

  assign prod_fix = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
  assign quo_raw  = acc_q[WIDTH-1:0];
  assign quo_fix  = (a_neg_q ^ b_neg_q) ? -quo_raw : quo_raw;
  assign rem_fix  = a_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  always_comb begin
    if (fast_q)          fix_val = quo_raw;
    else if (!f3_q[2])   fix_val = (f3_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0]
                                                        : prod_fix[2*WIDTH-1:WIDTH];
    else                 fix_val = f3_q[1] ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_acc) state_d = is_fast ? S_FIX : S_CALC;
      S_CALC:  if (cnt_q == CW'(1)) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = start_acc ? (is_fast ? S_FIX : S_CALC) : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Busy = (state_q == S_CALC) || (state_q == S_FIX);
    Done = (state_q == S_DONE);
  end
  assign Result = result_q;

  always_comb begin
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    fast_d   = fast_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;
    if (start_acc) begin
      f3_d    = Funct3;
      a_neg_d = a_neg;
      b_neg_d = b_neg;
      fast_d  = is_fast;
      cnt_d   = is_fast ? '0 : CW'(WIDTH);
      rem_d   = '0;
      opnd_d  = is_div ? b_mag : a_mag;
      acc_d   = {{WIDTH{1'b0}}, (is_fast ? fast_val : (is_div ? a_mag : b_mag))};
    end else if (state_q == S_CALC) begin
      cnt_d = cnt_q - CW'(1);
      if (!f3_q[2]) begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end else if (div_diff[WIDTH+1]) begin
        rem_d = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        rem_d = div_diff[WIDTH:0];
        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
      end
    end else if (state_q == S_FIX) begin
      result_d = fix_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      f3_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      fast_q   <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      fast_q   <= fast_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: results, latency, Busy/Done framing,
// ignored/back-to-back Start and asynchronous reset mid-operation.
module tb_mul_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         Start;
  logic [2:0]   Funct3;
  logic [W-1:0] SrcA, SrcB, Result;
  logic         Busy, Done;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .Funct3 (Funct3),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues Start at the current time; n counts edges with the Start edge as 1.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int lat,
                        input int glitch_at);
    int   n;
    logic busy_ok;
    Funct3 = f3; SrcA = a; SrcB = b; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; SrcA = $urandom; SrcB = $urandom; Funct3 = 3'($urandom);
    n = 1;
    busy_ok = 1'b1;
    while (!Done && n < 200) begin
      if (!Busy) busy_ok = 1'b0;
      if (n == glitch_at) begin
        Start = 1'b1; Funct3 = 3'b101; SrcA = 32'd1000; SrcB = 32'd3;
      end
      @(posedge clk); #1;
      Start = 1'b0;
      n++;
    end
    check({tag, "_latency"}, W'(n), W'(lat));
    check({tag, "_busy_until_done"}, W'(busy_ok), W'(1));
    check({tag, "_busy_at_done"}, W'(Busy), W'(0));
    check({tag, "_result"}, Result, exp);
  endtask

  task automatic idle(input string tag);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, W'(Done), W'(0));
  endtask

  initial begin
    reset = 1'b0; Start = 1'b0; Funct3 = 3'b000; SrcA = '0; SrcB = '0;
    #1;
    check("rst_busy", W'(Busy), W'(0));
    check("rst_done", W'(Done), W'(0));
    check("rst_result", Result, '0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    run_op("mul_7x6",      3'b000, 32'd7,        32'd6,        32'h0000002A, 34, 0); idle("mul_7x6");
    run_op("mulh_m1x2",    3'b001, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, 0); idle("mulh_m1x2");
    run_op("mulhu_m1x2",   3'b011, 32'hFFFFFFFF, 32'd2,        32'h00000001, 34, 0); idle("mulhu_m1x2");
    run_op("mulhsu_m1",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 0); idle("mulhsu_m1");
    run_op("mul_m3x5",     3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 34, 0); idle("mul_m3x5");
    run_op("mulh_min2",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 0); idle("mulh_min2");
    run_op("div_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 0); idle("div_m7_2");
    run_op("rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 0); idle("rem_m7_2");
    run_op("div_m7_m2",    3'b100, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 34, 0); idle("div_m7_m2");
    run_op("divu_100_7",   3'b101, 32'd100,      32'd7,        32'd14,       34, 0); idle("divu_100_7");
    run_op("remu_100_7",   3'b111, 32'd100,      32'd7,        32'd2,        34, 0); idle("remu_100_7");
    run_op("divu_ones",    3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34, 0); idle("divu_ones");
    run_op("div_min_2",    3'b100, 32'h80000000, 32'd2,        32'hC0000000, 34, 0); idle("div_min_2");
    run_op("divu_by0",     3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 2,  0); idle("divu_by0");
    run_op("remu_by0",     3'b111, 32'd5,        32'd0,        32'h00000005, 2,  0); idle("remu_by0");
    run_op("div_by0",      3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 2,  0); idle("div_by0");
    run_op("rem_by0",      3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 2,  0); idle("rem_by0");
    run_op("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2,  0); idle("div_ovf");
    run_op("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2,  0); idle("rem_ovf");

    run_op("calc_start",   3'b000, 32'd7,        32'd6,        32'h0000002A, 34, 5); idle("calc_start");

    run_op("b2b_first",    3'b000, 32'd7,        32'd6,        32'h0000002A, 34, 0);
    run_op("b2b_second",   3'b101, 32'd100,      32'd7,        32'd14,       34, 0); idle("b2b_second");

    Funct3 = 3'b000; SrcA = 32'd11; SrcB = 32'd13; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("arst_busy", W'(Busy), W'(0));
    check("arst_done", W'(Done), W'(0));
    check("arst_result", Result, '0);
    @(posedge clk); #1;
    check("arst_hold_busy", W'(Busy), W'(0));
    reset = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst_mul", 3'b000, 32'd3,        32'd3,        32'd9,        34, 0); idle("post_rst_mul");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
